// File: rtl/mem_wb_stage.sv
// Memory + writeback stage: issues loads/stores over a ready/valid handshake,
// stalls the upstream EX/MEM register, and produces the registered writeback triple.
module mem_wb_stage #(
    parameter int BIT_WIDTH = 32,
    parameter int TIMEOUT   = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 regWrEnIn,
    input  logic                 memWrEnIn,
    input  logic [1:0]           mulSelIn,
    input  logic [3:0]           regWrAddrIn,
    input  logic [BIT_WIDTH-1:0] aluOutIn,
    input  logic [BIT_WIDTH-1:0] PCIn,
    input  logic [BIT_WIDTH-1:0] dataInIn,
    output logic                 stall,
    output logic                 memReq,
    output logic                 memWe,
    output logic [BIT_WIDTH-1:0] memAddr,
    output logic [BIT_WIDTH-1:0] memWrData,
    input  logic                 memReady,
    input  logic                 memRdValid,
    input  logic [BIT_WIDTH-1:0] memRdData,
    output logic                 wbEn,
    output logic [3:0]           wbAddr,
    output logic [BIT_WIDTH-1:0] wbData,
    output logic                 memErr
);

    typedef enum logic [1:0] {IDLE, WAIT_RD, ERROR} state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t               state;
    logic [7:0]           cnt;
    logic [7:0]           cnt_inc;
    logic                 sel_load;
    logic                 is_store;
    logic                 is_load;
    logic                 is_mem;
    logic                 retire;
    logic [BIT_WIDTH-1:0] wb_data_next;

    // A store wins when both store enable and load select are present.
    assign sel_load  = (mulSelIn == 2'b01);
    assign is_store  = memWrEnIn;
    assign is_load   = sel_load & ~memWrEnIn;
    assign is_mem    = sel_load | memWrEnIn;
    assign memAddr   = aluOutIn;
    assign memWrData = dataInIn;
    assign cnt_inc   = cnt + 8'd1;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        stall  = 1'b0;
        memReq = 1'b0;
        memWe  = 1'b0;
        retire = 1'b0;
        case (state)
            IDLE: begin
                memReq = is_mem;
                memWe  = is_store;
                if (is_mem && !memReady) stall  = 1'b1;
                else if (is_load)        stall  = 1'b1;
                else                     retire = 1'b1;
            end
            WAIT_RD: begin
                if (memRdValid) retire = 1'b1;
                else            stall  = 1'b1;
            end
            default: stall = 1'b1;
        endcase
    end

    // Load data is only meaningful once a load retires out of WAIT_RD.
    always_comb begin
        case (mulSelIn)
            2'b01:   wb_data_next = (state == WAIT_RD) ? memRdData : '0;
            2'b10:   wb_data_next = PCIn;
            default: wb_data_next = aluOutIn;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            cnt    <= '0;
            wbEn   <= 1'b0;
            wbAddr <= '0;
            wbData <= '0;
            memErr <= 1'b0;
        end else begin
            wbEn <= retire & regWrEnIn;
            if (retire) begin
                wbAddr <= regWrAddrIn;
                wbData <= wb_data_next;
            end
            case (state)
                IDLE: begin
                    if (is_load && memReady) begin
                        state <= WAIT_RD;
                        cnt   <= '0;
                    end
                end
                WAIT_RD: begin
                    if (memRdValid) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt_inc;
                        if (cnt_inc == TIMEOUT_CNT) begin
                            state  <= ERROR;
                            memErr <= 1'b1;
                        end
                    end
                end
                default: state <= ERROR;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Directed self-checking bench for mem_wb_stage: single-cycle vector table
// plus hand-written store-wait, load, timeout and reset-mid-load sequences.
module tb_mem_wb_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        regWrEnIn, memWrEnIn;
    logic [1:0]  mulSelIn;
    logic [3:0]  regWrAddrIn;
    logic [31:0] aluOutIn, PCIn, dataInIn;
    logic        stall, memReq, memWe;
    logic [31:0] memAddr, memWrData;
    logic        memReady, memRdValid;
    logic [31:0] memRdData;
    logic        wbEn;
    logic [3:0]  wbAddr;
    logic [31:0] wbData;
    logic        memErr;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    mem_wb_stage #(.BIT_WIDTH(32), .TIMEOUT(16)) dut (
        .clk(clk), .reset(reset),
        .regWrEnIn(regWrEnIn), .memWrEnIn(memWrEnIn), .mulSelIn(mulSelIn),
        .regWrAddrIn(regWrAddrIn), .aluOutIn(aluOutIn), .PCIn(PCIn), .dataInIn(dataInIn),
        .stall(stall), .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWrData(memWrData),
        .memReady(memReady), .memRdValid(memRdValid), .memRdData(memRdData),
        .wbEn(wbEn), .wbAddr(wbAddr), .wbData(wbData), .memErr(memErr)
    );

    typedef struct {
        logic        rw, mw;
        logic [1:0]  sel;
        logic [3:0]  addr;
        logic [31:0] alu, pc, din;
        logic        rdy, rv;
        logic [31:0] rd;
    } in_t;

    typedef struct {
        in_t         i;
        logic        stall, req, we, wb_en;
        logic [3:0]  wb_addr;
        logic [31:0] wb_data;
    } vec_t;

    function automatic in_t mk(logic rw, logic mw, logic [1:0] sel, logic [3:0] addr,
                               logic [31:0] alu, logic [31:0] pc, logic [31:0] din,
                               logic rdy, logic rv, logic [31:0] rd);
        in_t v;
        v.rw = rw; v.mw = mw; v.sel = sel; v.addr = addr; v.alu = alu;
        v.pc = pc; v.din = din; v.rdy = rdy; v.rv = rv; v.rd = rd;
        return v;
    endfunction

    task automatic apply(input in_t v);
        regWrEnIn = v.rw; memWrEnIn = v.mw; mulSelIn = v.sel; regWrAddrIn = v.addr;
        aluOutIn = v.alu; PCIn = v.pc; dataInIn = v.din;
        memReady = v.rdy; memRdValid = v.rv; memRdData = v.rd;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive at the falling edge, sample combinational outputs 1ns later.
    task automatic drive(input in_t v);
        @(negedge clk);
        apply(v);
        #1;
    endtask

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    vec_t vec[7];
    in_t  zero_in, ld;

    initial begin
        zero_in = mk(0, 0, 2'b00, 4'd0, 32'h0, 32'h0, 32'h0, 0, 0, 32'h0);
        vec[0] = '{i: mk(1, 0, 2'b00, 4'd5, 32'h42,   32'h0,  32'h0,    0, 0, 32'h0),
                   stall: 0, req: 0, we: 0, wb_en: 1, wb_addr: 4'd5, wb_data: 32'h42};
        vec[1] = '{i: mk(1, 0, 2'b10, 4'd7, 32'h99,   32'h40, 32'h0,    0, 0, 32'h0),
                   stall: 0, req: 0, we: 0, wb_en: 1, wb_addr: 4'd7, wb_data: 32'h40};
        vec[2] = '{i: mk(1, 0, 2'b11, 4'd2, 32'hDEAD, 32'h8,  32'h0,    0, 0, 32'h0),
                   stall: 0, req: 0, we: 0, wb_en: 1, wb_addr: 4'd2, wb_data: 32'hDEAD};
        vec[3] = '{i: zero_in,
                   stall: 0, req: 0, we: 0, wb_en: 0, wb_addr: 4'd0, wb_data: 32'h0};
        vec[4] = '{i: mk(0, 1, 2'b00, 4'd0, 32'h100,  32'h0,  32'hCAFE, 1, 0, 32'h0),
                   stall: 0, req: 1, we: 1, wb_en: 0, wb_addr: 4'd0, wb_data: 32'h100};
        vec[5] = '{i: mk(1, 1, 2'b01, 4'd9, 32'h200,  32'h0,  32'h55,   1, 0, 32'h0),
                   stall: 0, req: 1, we: 1, wb_en: 1, wb_addr: 4'd9, wb_data: 32'h0};
        vec[6] = '{i: mk(1, 0, 2'b00, 4'd4, 32'h77,   32'h0,  32'h0,    0, 1, 32'hBAD),
                   stall: 0, req: 0, we: 0, wb_en: 1, wb_addr: 4'd4, wb_data: 32'h77};

        apply(zero_in);
        reset = 1'b0;
        #23;
        check("reset_wbEn",   32'(wbEn),   32'h0);
        check("reset_wbAddr", 32'(wbAddr), 32'h0);
        check("reset_wbData", wbData,      32'h0);
        check("reset_memErr", 32'(memErr), 32'h0);
        check("reset_stall",  32'(stall),  32'h0);
        @(negedge clk);
        reset = 1'b1;

        for (int k = 0; k < 7; k++) begin
            drive(vec[k].i);
            check($sformatf("v%0d_stall", k),     32'(stall),  32'(vec[k].stall));
            check($sformatf("v%0d_memReq", k),    32'(memReq), 32'(vec[k].req));
            check($sformatf("v%0d_memWe", k),     32'(memWe),  32'(vec[k].we));
            check($sformatf("v%0d_memAddr", k),   memAddr,     vec[k].i.alu);
            check($sformatf("v%0d_memWrData", k), memWrData,   vec[k].i.din);
            edge_sample();
            check($sformatf("v%0d_wbEn", k),   32'(wbEn),   32'(vec[k].wb_en));
            check($sformatf("v%0d_wbAddr", k), 32'(wbAddr), 32'(vec[k].wb_addr));
            check($sformatf("v%0d_wbData", k), wbData,      vec[k].wb_data);
        end

        // Store held off by memReady for two cycles.
        for (int k = 0; k < 2; k++) begin
            drive(mk(0, 1, 2'b00, 4'd1, 32'h100, 32'h0, 32'hCAFE, 0, 0, 32'h0));
            check("st_wait_stall",  32'(stall),  32'h1);
            check("st_wait_memReq", 32'(memReq), 32'h1);
            edge_sample();
            check("st_wait_wbEn", 32'(wbEn), 32'h0);
        end
        drive(mk(0, 1, 2'b00, 4'd1, 32'h100, 32'h0, 32'hCAFE, 1, 0, 32'h0));
        check("st_acc_stall",     32'(stall),  32'h0);
        check("st_acc_memWe",     32'(memWe),  32'h1);
        check("st_acc_memAddr",   memAddr,     32'h100);
        check("st_acc_memWrData", memWrData,   32'hCAFE);
        edge_sample();
        check("st_acc_wbEn", 32'(wbEn), 32'h0);

        // Load accepted, data three cycles later.
        ld = mk(1, 0, 2'b01, 4'd3, 32'h300, 32'h0, 32'h0, 1, 0, 32'h0);
        drive(ld);
        check("ld_acc_stall",  32'(stall),  32'h1);
        check("ld_acc_memReq", 32'(memReq), 32'h1);
        check("ld_acc_memWe",  32'(memWe),  32'h0);
        edge_sample();
        check("ld_acc_wbEn", 32'(wbEn), 32'h0);
        for (int k = 0; k < 2; k++) begin
            drive(ld);
            check("ld_wait_stall",  32'(stall),  32'h1);
            check("ld_wait_memReq", 32'(memReq), 32'h0);
            edge_sample();
            check("ld_wait_wbEn", 32'(wbEn), 32'h0);
        end
        drive(mk(1, 0, 2'b01, 4'd3, 32'h300, 32'h0, 32'h0, 1, 1, 32'h1234));
        check("ld_rv_stall",  32'(stall),  32'h0);
        check("ld_rv_memReq", 32'(memReq), 32'h0);
        edge_sample();
        check("ld_wbEn",   32'(wbEn),   32'h1);
        check("ld_wbAddr", 32'(wbAddr), 32'h3);
        check("ld_wbData", wbData,      32'h1234);
        drive(zero_in);
        edge_sample();
        check("ld_no_dup_wbEn", 32'(wbEn), 32'h0);

        // Load that never returns data: timeout into ERROR.
        drive(ld);
        edge_sample();
        for (int k = 1; k <= 16; k++) begin
            drive(mk(1, 0, 2'b01, 4'd3, 32'h300, 32'h0, 32'h0, 0, 0, 32'h0));
            check("to_wait_stall", 32'(stall), 32'h1);
            edge_sample();
            if (k < 16) check($sformatf("to_err_early_%0d", k), 32'(memErr), 32'h0);
        end
        check("to_memErr", 32'(memErr), 32'h1);
        for (int k = 0; k < 3; k++) begin
            drive(mk(1, 0, 2'b00, 4'd6, 32'h66, 32'h0, 32'h0, 1, 1, 32'h5A5A));
            check("err_stall",  32'(stall),  32'h1);
            check("err_memReq", 32'(memReq), 32'h0);
            edge_sample();
            check("err_wbEn",   32'(wbEn),   32'h0);
            check("err_sticky", 32'(memErr), 32'h1);
        end
        reset = 1'b0;
        #1;
        check("err_rst_memErr", 32'(memErr), 32'h0);
        check("err_rst_wbEn",   32'(wbEn),   32'h0);
        check("err_rst_stall_plain", 32'(stall), 32'h0);
        apply(mk(0, 1, 2'b00, 4'd0, 32'h10, 32'h0, 32'h1, 0, 0, 32'h0));
        #1;
        check("err_rst_stall_mem",  32'(stall),  32'h1);
        check("err_rst_memReq_mem", 32'(memReq), 32'h1);
        @(negedge clk);
        reset = 1'b1;

        // Reset while a load is in flight, then a late memRdValid.
        drive(ld);
        edge_sample();
        drive(mk(1, 0, 2'b01, 4'd3, 32'h300, 32'h0, 32'h0, 0, 0, 32'h0));
        #2;
        reset = 1'b0;
        #1;
        check("mid_rst_stall", 32'(stall), 32'h1);
        check("mid_rst_memReq_idle", 32'(memReq), 32'h1);
        @(negedge clk);
        reset = 1'b1;
        drive(mk(1, 0, 2'b00, 4'd8, 32'h88, 32'h0, 32'h0, 0, 1, 32'hBEEF));
        edge_sample();
        check("mid_late_rv_wbData", wbData, 32'h88);
        drive(mk(0, 0, 2'b00, 4'd0, 32'h0, 32'h0, 32'h0, 0, 1, 32'hBEEF));
        edge_sample();
        check("mid_late_rv_wbEn", 32'(wbEn), 32'h0);
        drive(mk(1, 0, 2'b01, 4'd3, 32'h300, 32'h0, 32'h0, 0, 0, 32'h0));
        check("mid_memReq_follows", 32'(memReq), 32'h1);
        check("mid_stall_follows",  32'(stall),  32'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Consumer side of the EX/MEM pipeline register; takes the buffered control and data fields and performs the memory stage and the writeback stage.
- Issues loads and stores to the data memory over a request/response handshake.
- Drives `stall` back to the pipeline register, whose write enable is `~stall`.
- Produces the registered register-file writeback triple `wbEn`, `wbAddr` and `wbData`.

Parameters:
- BIT_WIDTH, 32, datapath width: aluOut, PC, dataIn, memory address and data.
- TIMEOUT, 16, maximum cycles to wait for load data after request acceptance; range 1..255.

Ports:
- clk  input  1  clock, rising-edge.
- reset  input  1  asynchronous, active-low reset.
- regWrEnIn  input  1  buffered register write enable.
- memWrEnIn  input  1  buffered store enable.
- mulSelIn  input  2  writeback select: 00 ALU, 01 load data, 10 PC, 11 ALU. 01 marks a load.
- regWrAddrIn  input  4  destination register.
- aluOutIn  input  BIT_WIDTH  ALU result; also the memory address.
- PCIn  input  BIT_WIDTH  PC value to write back (link).
- dataInIn  input  BIT_WIDTH  store data.
- stall  output  1  hold the upstream pipeline register.
- memReq  output  1  memory request valid.
- memWe  output  1  1 = store, 0 = load.
- memAddr  output  BIT_WIDTH  equals aluOutIn.
- memWrData  output  BIT_WIDTH  equals dataInIn.
- memReady  input  1  memory accepts the request this cycle.
- memRdValid  input  1  load data valid.
- memRdData  input  BIT_WIDTH  load data.
- wbEn  output  1  register-file write enable, registered.
- wbAddr  output  4  registered.
- wbData  output  BIT_WIDTH  registered.
- memErr  output  1  sticky load-timeout flag.

Behaviour:
- Op classes at the input:
  - load = (mulSelIn == 01).
  - store = memWrEnIn.
  - mem op = load OR store.
  - plain op = otherwise; an all-zero bubble is a plain op with regWrEn = 0.
  - load and store both set: treated as store; writeback selects load data = 0.
- FSM states: IDLE, WAIT_RD, ERROR.
- IDLE:
  - memReq = mem op; memWe = store.
  - Mem op with memReady = 0: stall = 1, stay in IDLE; the request repeats next cycle with held inputs.
  - Store with memReady = 1: retires this cycle, stall = 0.
  - Load with memReady = 1: stall = 1, counter cleared, go to WAIT_RD.
  - Plain op: retires this cycle, stall = 0.
  - memRdValid is ignored in IDLE; minimum load latency is 1 cycle after acceptance.
- WAIT_RD:
  - memReq = 0; the held input is never re-issued.
  - memRdValid = 1: load retires, stall = 0, go to IDLE.
  - Otherwise the counter increments and stall = 1.
  - Counter reaches TIMEOUT without memRdValid: go to ERROR.
- ERROR:
  - stall = 1, memReq = 0, memErr = 1.
  - Held until reset; no further writebacks.
- Writeback (registered, 1 cycle after retirement):
  - wbEn <= regWrEnIn of the retiring op.
  - wbAddr <= regWrAddrIn.
  - wbData <= ALU / memRdData / PC per mulSelIn.
  - wbEn = 0 in every cycle following a non-retiring cycle; there are no duplicate writes while stalled.
- Reset (asynchronous, also mid-operation):
  - state = IDLE; wbEn = 0, wbAddr = 0, wbData = 0; memErr = 0; counter = 0.
  - An in-flight load is abandoned; a late memRdValid after reset is ignored because state is IDLE.
- Combinational outputs (stall, memReq, memWe, memAddr, memWrData) reset to the IDLE decode of the current inputs.
- Widths: counter is 8 bits; no arithmetic on the datapath.

Test Plan:
- Plain op: regWrEn = 1, mulSel = 00, aluOut = 0x0000_0042, addr = 5.
  - Required: stall = 0.
  - Next cycle: wbEn = 1, wbAddr = 5, wbData = 0x42.
- Store: memWrEn = 1, aluOut = 0x100, dataIn = 0xCAFE, memReady low for 2 cycles then high.
  - Required: memReq = 1 and stall = 1 for 2 cycles.
  - Acceptance cycle: stall = 0, memWe = 1, memAddr = 0x100, memWrData = 0xCAFE.
  - wbEn = 0 throughout.
- Load: mulSel = 01, addr = 3, memReady = 1; memRdValid with 0x1234 three cycles later.
  - Required: stall = 1 for 3 cycles, memReq high only in the first cycle.
  - Next cycle after memRdValid: wbEn = 1, wbAddr = 3, wbData = 0x1234.
- Link: mulSel = 10, PC = 0x0000_0040, regWrEn = 1.
  - Required: next cycle wbData = 0x40.
- Timeout: load accepted, memRdValid never asserted, TIMEOUT = 16.
  - Required: memErr = 1 after 16 WAIT_RD cycles; stall stays 1; wbEn stays 0.
  - Asserting reset low clears memErr, stall follows the inputs, wbEn = 0.
- Reset mid-load: assert reset in WAIT_RD, release, then pulse memRdValid.
  - Required: no writeback, state IDLE, memReq follows the current inputs.
